// File: rtl/hyperram_seq.sv
// rtl/hyperram_seq.sv - HyperRAM transaction sequencer driving the hyperram_io PHY
module hyperram_seq #(
    parameter int LATENCY    = 6,
    parameter int LEN_W      = 6,
    parameter int RD_TIMEOUT = 32,
    parameter int RST_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic             cmd_reg,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [15:0]      wr_data,
    input  logic [1:0]       wr_mask,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    output logic [1:0]       err,
    output logic             phy_ce_n,
    output logic             phy_rst_n,
    output logic             phy_ck_en,
    output logic             phy_dq_dir,
    output logic             phy_rwds_dir,
    output logic [7:0]       phy_dq_out0,
    output logic [7:0]       phy_dq_out1,
    output logic             phy_rwds_out0,
    output logic             phy_rwds_out1,
    input  logic [7:0]       phy_dq_in0,
    input  logic [7:0]       phy_dq_in1,
    input  logic             phy_rwds_in0,
    input  logic             phy_rwds_in1
);
    // One shared cycle counter covers reset timing, latency and burst length.
    localparam int CNT_W = 16;

    localparam logic [3:0] S_RST_LO   = 4'd0;
    localparam logic [3:0] S_RST_WAIT = 4'd1;
    localparam logic [3:0] S_IDLE     = 4'd2;
    localparam logic [3:0] S_CA0      = 4'd3;
    localparam logic [3:0] S_CA1      = 4'd4;
    localparam logic [3:0] S_CA2      = 4'd5;
    localparam logic [3:0] S_LAT      = 4'd6;
    localparam logic [3:0] S_WDATA    = 4'd7;
    localparam logic [3:0] S_RDATA    = 4'd8;
    localparam logic [3:0] S_HOLD     = 4'd9;

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_to;
    logic [47:0]      r_ca;
    logic [LEN_W-1:0] r_len;
    logic             r_we;
    logic             r_reg;
    logic             r_dbl;
    logic [1:0]       r_err;
    logic [15:0]      r_rd_data;
    logic             r_rd_valid;

    logic [CNT_W-1:0] w_lat_last;
    logic [CNT_W-1:0] w_len_last;
    logic             w_rd_word;

    // LAT lasts L-1 cycles, so the last count is L-2.
    assign w_lat_last = r_dbl ? CNT_W'(2 * LATENCY - 2) : CNT_W'(LATENCY - 2);
    assign w_len_last = CNT_W'(r_len);
    // A read word is marked by an RWDS rising/falling pair within one CK cycle.
    assign w_rd_word  = phy_rwds_in0 & ~phy_rwds_in1;

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

    // Sequencer state, counters, command capture, read capture and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RST_LO;
            r_cnt      <= '0;
            r_to       <= '0;
            r_ca       <= '0;
            r_len      <= '0;
            r_we       <= 1'b0;
            r_reg      <= 1'b0;
            r_dbl      <= 1'b0;
            r_err      <= 2'b00;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_RST_LO: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_state <= S_RST_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state <= S_CA0;
                        r_ca    <= {~cmd_we, cmd_reg, 1'b1, cmd_addr[31:3], 13'b0, cmd_addr[2:0]};
                        r_we    <= cmd_we;
                        r_reg   <= cmd_reg;
                        r_len   <= cmd_len;
                        r_err   <= 2'b00;
                    end
                end
                S_CA0: begin
                    r_dbl   <= phy_rwds_in0;
                    r_state <= S_CA1;
                end
                S_CA1: r_state <= S_CA2;
                S_CA2: begin
                    r_cnt   <= '0;
                    r_to    <= '0;
                    r_state <= (r_we && r_reg) ? S_WDATA : S_LAT;
                end
                S_LAT: begin
                    if (r_cnt == w_lat_last) begin
                        r_cnt   <= '0;
                        r_to    <= '0;
                        r_state <= r_we ? S_WDATA : S_RDATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (!wr_valid) begin
                        r_err[1] <= 1'b1;
                    end
                    if (r_reg || r_cnt == w_len_last) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RDATA: begin
                    if (w_rd_word) begin
                        r_rd_data  <= {phy_dq_in0, phy_dq_in1};
                        r_rd_valid <= 1'b1;
                        r_to       <= '0;
                        if (r_cnt == w_len_last) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_to == CNT_W'(RD_TIMEOUT - 1)) begin
                        r_err[0] <= 1'b1;
                        r_state  <= S_HOLD;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_HOLD:  r_state <= S_IDLE;
                default: r_state <= S_RST_LO;
            endcase
        end
    end

    // PHY and handshake outputs decoded from the current state.
    always_comb begin
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        phy_ce_n      = 1'b1;
        phy_rst_n     = 1'b1;
        phy_ck_en     = 1'b0;
        phy_dq_dir    = 1'b0;
        phy_rwds_dir  = 1'b0;
        phy_dq_out0   = 8'h00;
        phy_dq_out1   = 8'h00;
        phy_rwds_out0 = 1'b0;
        phy_rwds_out1 = 1'b0;
        case (r_state)
            S_RST_LO: phy_rst_n = 1'b0;
            S_IDLE:   cmd_ready = 1'b1;
            S_CA0: begin
                phy_ce_n    = 1'b0;
                phy_ck_en   = 1'b1;
                phy_dq_dir  = 1'b1;
                phy_dq_out0 = r_ca[47:40];
                phy_dq_out1 = r_ca[39:32];
            end
            S_CA1: begin
                phy_ce_n    = 1'b0;
                phy_ck_en   = 1'b1;
                phy_dq_dir  = 1'b1;
                phy_dq_out0 = r_ca[31:24];
                phy_dq_out1 = r_ca[23:16];
            end
            S_CA2: begin
                phy_ce_n    = 1'b0;
                phy_ck_en   = 1'b1;
                phy_dq_dir  = 1'b1;
                phy_dq_out0 = r_ca[15:8];
                phy_dq_out1 = r_ca[7:0];
            end
            S_LAT, S_RDATA: begin
                phy_ce_n  = 1'b0;
                phy_ck_en = 1'b1;
            end
            S_WDATA: begin
                phy_ce_n      = 1'b0;
                phy_ck_en     = 1'b1;
                phy_dq_dir    = 1'b1;
                phy_rwds_dir  = ~r_reg;
                wr_ready      = 1'b1;
                phy_dq_out0   = wr_data[15:8];
                phy_dq_out1   = wr_data[7:0];
                // A missing word is fully masked so the device keeps old data.
                phy_rwds_out0 = wr_valid ? wr_mask[1] : 1'b1;
                phy_rwds_out1 = wr_valid ? wr_mask[0] : 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_hyperram_seq.sv
// tb/tb_hyperram_seq.sv - self-checking bench for hyperram_seq
module tb_hyperram_seq;
    localparam int LATENCY    = 6;
    localparam int LEN_W      = 6;
    localparam int RD_TIMEOUT = 32;
    localparam int RST_CYCLES = 16;
    localparam int SZ         = 1024;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_we = 1'b0;
    logic             cmd_reg = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [15:0]      wr_data = '0;
    logic [1:0]       wr_mask = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [15:0]      rd_data;
    logic             rd_valid;
    logic [1:0]       err;
    logic             phy_ce_n, phy_rst_n, phy_ck_en, phy_dq_dir, phy_rwds_dir;
    logic [7:0]       phy_dq_out0, phy_dq_out1;
    logic             phy_rwds_out0, phy_rwds_out1;
    logic [7:0]       phy_dq_in0 = '0;
    logic [7:0]       phy_dq_in1 = '0;
    logic             phy_rwds_in0 = 1'b0;
    logic             phy_rwds_in1 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle stimulus and expectation tables, indexed from the CA0 cycle.
    logic        s_r0 [0:SZ-1];
    logic        s_r1 [0:SZ-1];
    logic [15:0] s_dq [0:SZ-1];
    logic        e_rv [0:SZ-1];
    logic [15:0] e_rd [0:SZ-1];
    logic [15:0] wd   [0:SZ-1];
    logic [1:0]  wm   [0:SZ-1];
    logic        wv   [0:SZ-1];

    hyperram_seq #(
        .LATENCY(LATENCY), .LEN_W(LEN_W), .RD_TIMEOUT(RD_TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
        .phy_ce_n(phy_ce_n), .phy_rst_n(phy_rst_n), .phy_ck_en(phy_ck_en),
        .phy_dq_dir(phy_dq_dir), .phy_rwds_dir(phy_rwds_dir),
        .phy_dq_out0(phy_dq_out0), .phy_dq_out1(phy_dq_out1),
        .phy_rwds_out0(phy_rwds_out0), .phy_rwds_out1(phy_rwds_out1),
        .phy_dq_in0(phy_dq_in0), .phy_dq_in1(phy_dq_in1),
        .phy_rwds_in0(phy_rwds_in0), .phy_rwds_in1(phy_rwds_in1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ca_byte(input bit we, input bit rg, input logic [31:0] a, input int i);
        logic [63:0] ca;
        ca = (64'(!we) << 47) + (64'(rg) << 46) + (64'd1 << 45) + (64'(a >> 3) << 16) + 64'(a % 8);
        return 8'((ca >> (40 - 8 * i)) & 64'hFF);
    endfunction

    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s wait_cmd_ready got timeout want cmd_ready=1", name);
        end
    endtask

    task automatic test_reset;
        int n_lo, n_hi;
        logic [33:0] obs;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        obs = {cmd_ready, wr_ready, rd_valid, err, phy_ce_n, phy_rst_n, phy_ck_en, phy_dq_dir,
               phy_rwds_dir, phy_dq_out0, phy_dq_out1, phy_rwds_out0, phy_rwds_out1, 8'h00};
        rst = 1'b0;
        n_cmp++;
        if (obs !== {3'b000, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 2'b00, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want %h", obs, {3'b000, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 2'b00, 8'h00});
        end
        n_lo = 1;
        n_hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (phy_rst_n !== 1'b0) break;
            n_lo++;
        end
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready === 1'b1) break;
            n_hi++;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (n_lo != RST_CYCLES) begin
            n_bad++;
            $display("FAIL reset_rst_n_low_cycles got %0d want %0d", n_lo, RST_CYCLES);
        end
        n_cmp++;
        if (n_hi != RST_CYCLES) begin
            n_bad++;
            $display("FAIL reset_wait_cycles got %0d want %0d", n_hi, RST_CYCLES);
        end
    endtask

    task automatic test_read(input string name, input bit rg, input logic [31:0] addr, input int len,
                             input bit dbl, input int n_sup, input int gap_max, input bit gap31);
        int lat, nc, n_low, g, pat;
        bit ok, to_exp;
        logic [4:0] obs, exp;
        for (int i = 0; i < SZ; i++) begin
            s_r0[i] = 1'b0; s_r1[i] = 1'b0; s_dq[i] = '0; e_rv[i] = 1'b0; e_rd[i] = '0;
        end
        lat = (dbl ? 2 * LATENCY : LATENCY) - 1;
        s_r0[0] = dbl;
        nc = 3;
        // Strobes offered during latency must be ignored.
        for (int i = 0; i < lat; i++) begin
            s_r0[nc] = 1'b1; s_dq[nc] = 16'($urandom); nc++;
        end
        for (int w = 0; w < n_sup; w++) begin
            g = (gap31 && w == 1) ? RD_TIMEOUT - 1 : int'($urandom_range(gap_max, 0));
            for (int j = 0; j < g; j++) begin
                pat = int'($urandom_range(2, 0));
                s_r0[nc] = (pat == 1); s_r1[nc] = (pat != 0); s_dq[nc] = 16'($urandom); nc++;
            end
            s_r0[nc] = 1'b1; s_r1[nc] = 1'b0; s_dq[nc] = 16'($urandom);
            e_rv[nc + 1] = 1'b1; e_rd[nc + 1] = s_dq[nc];
            nc++;
        end
        to_exp = (n_sup < len + 1);
        n_low = nc + (to_exp ? RD_TIMEOUT : 0);
        wait_ready(name, ok);
        if (!ok) return;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_reg = rg; cmd_addr = addr; cmd_len = LEN_W'(len);
        for (int c = 0; c <= n_low + 1; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            phy_rwds_in0 = s_r0[c]; phy_rwds_in1 = s_r1[c]; {phy_dq_in0, phy_dq_in1} = s_dq[c];
            #1;
            obs = {phy_ce_n, phy_ck_en, phy_dq_dir, phy_rwds_dir, rd_valid};
            if (c < 3)          exp = {4'b0110, e_rv[c]};
            else if (c < n_low) exp = {4'b0100, e_rv[c]};
            else                exp = {4'b1000, e_rv[c]};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s ctl c=%0d got %b want %b", name, c, obs, exp);
            end
            if (c < 3) begin
                n_cmp++;
                if ({phy_dq_out0, phy_dq_out1} !== {ca_byte(0, rg, addr, 2 * c), ca_byte(0, rg, addr, 2 * c + 1)}) begin
                    n_bad++;
                    $display("FAIL %s ca c=%0d got %h want %h", name, c, {phy_dq_out0, phy_dq_out1},
                             {ca_byte(0, rg, addr, 2 * c), ca_byte(0, rg, addr, 2 * c + 1)});
                end
            end
            if (e_rv[c] && rd_valid) begin
                n_cmp++;
                if (rd_data !== e_rd[c]) begin
                    n_bad++;
                    $display("FAIL %s rd_data c=%0d got %h want %h", name, c, rd_data, e_rd[c]);
                end
            end
            if (c == n_low + 1) begin
                n_cmp++;
                if (cmd_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s cmd_ready_after_hold got %b want 1", name, cmd_ready);
                end
            end
        end
        phy_rwds_in0 = 1'b0; phy_rwds_in1 = 1'b0; phy_dq_in0 = '0; phy_dq_in1 = '0;
        n_cmp++;
        if (err !== {1'b0, to_exp}) begin
            n_bad++;
            $display("FAIL %s err got %b want %b", name, err, {1'b0, to_exp});
        end
    endtask

    task automatic test_write(input string name, input bit rg, input logic [31:0] addr, input int len,
                              input bit dbl, input logic [15:0] d0, input int under_pct, input int under_idx);
        int lat, nw, n_low, k;
        bit ok, any_under;
        logic [5:0] obs, exp;
        lat = rg ? 0 : (dbl ? 2 * LATENCY : LATENCY) - 1;
        nw = rg ? 1 : len + 1;
        n_low = 3 + lat + nw;
        any_under = 1'b0;
        for (int i = 0; i < nw; i++) begin
            wd[i] = (i == 0) ? d0 : 16'($urandom);
            wm[i] = 2'($urandom);
            wv[i] = (i != under_idx) && (int'($urandom_range(99, 0)) >= under_pct);
            if (!wv[i]) any_under = 1'b1;
        end
        wait_ready(name, ok);
        if (!ok) return;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_reg = rg; cmd_addr = addr; cmd_len = LEN_W'(len);
        for (int c = 0; c <= n_low + 1; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            phy_rwds_in0 = (c == 0) ? dbl : 1'b0;
            k = c - 3 - lat;
            if (k >= 0 && k < nw) begin
                wr_data = wd[k]; wr_mask = wm[k]; wr_valid = wv[k];
            end else begin
                wr_data = 16'($urandom); wr_mask = 2'($urandom); wr_valid = 1'b0;
            end
            #1;
            obs = {phy_ce_n, phy_ck_en, phy_dq_dir, phy_rwds_dir, wr_ready, cmd_ready};
            if (c < 3)            exp = 6'b011000;
            else if (c < 3 + lat) exp = 6'b010000;
            else if (c < n_low)   exp = {3'b011, !rg, 2'b10};
            else if (c == n_low)  exp = 6'b100000;
            else                  exp = 6'b100001;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s ctl c=%0d got %b want %b", name, c, obs, exp);
            end
            if (c < 3) begin
                n_cmp++;
                if ({phy_dq_out0, phy_dq_out1} !== {ca_byte(1, rg, addr, 2 * c), ca_byte(1, rg, addr, 2 * c + 1)}) begin
                    n_bad++;
                    $display("FAIL %s ca c=%0d got %h want %h", name, c, {phy_dq_out0, phy_dq_out1},
                             {ca_byte(1, rg, addr, 2 * c), ca_byte(1, rg, addr, 2 * c + 1)});
                end
            end
            if (k >= 0 && k < nw) begin
                n_cmp++;
                if ({phy_dq_out0, phy_dq_out1} !== wd[k]) begin
                    n_bad++;
                    $display("FAIL %s wdata k=%0d got %h want %h", name, k, {phy_dq_out0, phy_dq_out1}, wd[k]);
                end
                if (!rg) begin
                    n_cmp++;
                    if ({phy_rwds_out0, phy_rwds_out1} !== (wv[k] ? wm[k] : 2'b11)) begin
                        n_bad++;
                        $display("FAIL %s rwds k=%0d got %b want %b", name, k,
                                 {phy_rwds_out0, phy_rwds_out1}, (wv[k] ? wm[k] : 2'b11));
                    end
                end
            end
        end
        wr_valid = 1'b0; phy_rwds_in0 = 1'b0;
        n_cmp++;
        if (err !== {any_under, 1'b0}) begin
            n_bad++;
            $display("FAIL %s err got %b want %b", name, err, {any_under, 1'b0});
        end
    endtask

    task automatic test_reg_write;
        test_write("reg_write_8f1f", 1'b1, 32'h0, 0, 1'b0, 16'h8F1F, 0, -1);
        test_write("reg_write_rand", 1'b1, $urandom, int'($urandom_range(63, 0)), 1'b1, 16'($urandom), 0, -1);
    endtask

    task automatic test_timeout;
        test_read("timeout_none", 1'b0, $urandom, 3, 1'b0, 0, 0, 1'b0);
        test_read("timeout_part", 1'b0, $urandom, 5, 1'b1, 2, 3, 1'b0);
    endtask

    task automatic test_reset_mid_write;
        bit ok;
        int cw, k;
        logic [6:0] obs;
        cw = 3 + (LATENCY - 1) + 2;
        wait_ready("rst_mid_write", ok);
        if (!ok) return;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_reg = 1'b0; cmd_addr = $urandom; cmd_len = LEN_W'(7);
        for (int c = 0; c <= cw; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0; phy_rwds_in0 = 1'b0; wr_valid = 1'b0; wr_data = 16'($urandom);
            #1;
        end
        n_cmp++;
        if ({wr_ready, err} !== 3'b110) begin
            n_bad++;
            $display("FAIL rst_mid_write pre_reset got %b want 110", {wr_ready, err});
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        obs = {phy_ce_n, phy_rst_n, phy_ck_en, wr_ready, cmd_ready, err};
        n_cmp++;
        if (obs !== 7'b1000000) begin
            n_bad++;
            $display("FAIL rst_mid_write post_reset got %b want 1000000", obs);
        end
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            k++;
            if (wr_ready !== 1'b0) begin
                n_cmp++; n_bad++;
                $display("FAIL rst_mid_write stray_wr_ready got 1 want 0");
            end
            if (cmd_ready === 1'b1) break;
        end
        n_cmp++;
        if (k != 2 * RST_CYCLES) begin
            n_bad++;
            $display("FAIL rst_mid_write ready_delay got %0d want %0d", k, 2 * RST_CYCLES);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_read("read_fixed", 1'b0, 32'h0001_2345, 3, 1'b0, 4, 3, 1'b0);
        test_read("read_double", 1'b0, 32'h0001_2345, 3, 1'b1, 4, 3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            int ln;
            ln = int'($urandom_range(15, 0));
            test_read("read_rand", 1'($urandom), $urandom, ln, 1'($urandom), ln + 1, 4, 1'b0);
        end
        test_read("read_max_len", 1'b0, $urandom, 63, 1'b0, 64, 1, 1'b0);
        test_read("read_gap31", 1'b0, $urandom, 3, 1'b0, 4, 2, 1'b1);
        test_write("write_underrun", 1'b0, $urandom, 1, 1'b0, 16'($urandom), 0, 1);
        for (int i = 0; i < 5; i++) begin
            test_write("write_rand", 1'b0, $urandom, int'($urandom_range(15, 0)), 1'($urandom),
                       16'($urandom), (i < 2) ? 0 : 20, -1);
        end
        test_reg_write;
        test_timeout;
        test_read("read_clears_err", 1'b0, $urandom, 2, 1'b0, 3, 2, 1'b0);
        test_reset_mid_write;
        test_read("read_after_reset", 1'b0, $urandom, 4, 1'b1, 5, 3, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
